// File: rtl/fp16_result_collector.sv
// FP16 result collector: classifying FIFO with per-class statistics.
// Optional FP16_CANON_NAN_EN stores every NaN as canonical 0x7E00.
module fp16_result_collector #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [15:0]                in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [15:0]                out_data,
  output logic [2:0]                 out_class,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  input  logic                       clr_stat,
  output logic [CNT_W-1:0]           zero_cnt,
  output logic [CNT_W-1:0]           sub_cnt,
  output logic [CNT_W-1:0]           inf_cnt,
  output logic [CNT_W-1:0]           nan_cnt,
  output logic [3:0]                 sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [2:0] C_ZERO = 3'b000;
  localparam logic [2:0] C_SUB  = 3'b001;
  localparam logic [2:0] C_NORM = 3'b010;
  localparam logic [2:0] C_INF  = 3'b011;
  localparam logic [2:0] C_NAN  = 3'b100;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;
  logic [CNT_W-1:0] sub_cnt_q, sub_cnt_d;
  logic [CNT_W-1:0] inf_cnt_q, inf_cnt_d;
  logic [CNT_W-1:0] nan_cnt_q, nan_cnt_d;
  logic [3:0]       sticky_q, sticky_d;
  logic [18:0]      mem_q [DEPTH];

  logic [2:0]  in_cls;
  logic [15:0] wdata;
  logic        push;
  logic        pop;

  function automatic logic [2:0] classify(input logic [15:0] w);
    logic [2:0] c;
    c = C_NORM;
    unique case (1'b1)
      (w[14:10] == 5'd0)  && (w[9:0] == 10'd0): c = C_ZERO;
      (w[14:10] == 5'd0)  && (w[9:0] != 10'd0): c = C_SUB;
      (w[14:10] == 5'd31) && (w[9:0] == 10'd0): c = C_INF;
      (w[14:10] == 5'd31) && (w[9:0] != 10'd0): c = C_NAN;
      default: c = C_NORM;
    endcase
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Handshake flags come from registered occupancy only.
  assign in_ready  = (level_q != LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign out_data  = mem_q[rd_ptr_q][15:0];
  assign out_class = mem_q[rd_ptr_q][18:16];
  assign level     = level_q;
  assign zero_cnt  = zero_cnt_q;
  assign sub_cnt   = sub_cnt_q;
  assign inf_cnt   = inf_cnt_q;
  assign nan_cnt   = nan_cnt_q;
  assign sticky    = sticky_q;

  // Classify the incoming word and compute pointer, level and stats updates.
  always_comb begin
    in_cls     = classify(in_data);
`ifdef FP16_CANON_NAN_EN
    wdata      = (in_cls == C_NAN) ? 16'h7E00 : in_data;
`else
    wdata      = in_data;
`endif
    push       = in_valid && in_ready;
    pop        = out_valid && out_ready;
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    level_d    = level_q + LW'(push) - LW'(pop);
    zero_cnt_d = zero_cnt_q;
    sub_cnt_d  = sub_cnt_q;
    inf_cnt_d  = inf_cnt_q;
    nan_cnt_d  = nan_cnt_q;
    sticky_d   = sticky_q;
    if (clr_stat) begin
      zero_cnt_d = '0;
      sub_cnt_d  = '0;
      inf_cnt_d  = '0;
      nan_cnt_d  = '0;
      sticky_d   = '0;
    end else if (push) begin
      unique case (in_cls)
        C_ZERO: begin
          zero_cnt_d  = sat_inc(zero_cnt_q);
          sticky_d[0] = 1'b1;
        end
        C_SUB: begin
          sub_cnt_d   = sat_inc(sub_cnt_q);
          sticky_d[1] = 1'b1;
        end
        C_INF: begin
          inf_cnt_d   = sat_inc(inf_cnt_q);
          sticky_d[2] = 1'b1;
        end
        C_NAN: begin
          nan_cnt_d   = sat_inc(nan_cnt_q);
          sticky_d[3] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Control and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      zero_cnt_q <= '0;
      sub_cnt_q  <= '0;
      inf_cnt_q  <= '0;
      nan_cnt_q  <= '0;
      sticky_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      zero_cnt_q <= zero_cnt_d;
      sub_cnt_q  <= sub_cnt_d;
      inf_cnt_q  <= inf_cnt_d;
      nan_cnt_q  <= nan_cnt_d;
      sticky_q   <= sticky_d;
    end
  end

  // Entry storage; contents are only meaningful while occupied.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_cls, wdata};
  end

endmodule

// File: tb/tb_fp16_result_collector.sv
// Directed testbench for fp16_result_collector.
// Counters narrowed to 3 bits so saturation is reachable quickly.
module tb_fp16_result_collector;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [15:0]   in_data;
  logic          in_ready;
  logic          out_valid;
  logic [15:0]   out_data;
  logic [2:0]    out_class;
  logic          out_ready;
  logic [2:0]    level;
  logic          clr_stat;
  logic [CW-1:0] zero_cnt;
  logic [CW-1:0] sub_cnt;
  logic [CW-1:0] inf_cnt;
  logic [CW-1:0] nan_cnt;
  logic [3:0]    sticky;

  int checks;
  int errors;

`ifdef FP16_CANON_NAN_EN
  localparam logic [15:0] NAN1 = 16'h7E00;
  localparam logic [15:0] NAN2 = 16'h7E00;
`else
  localparam logic [15:0] NAN1 = 16'hFE01;
  localparam logic [15:0] NAN2 = 16'h7D00;
`endif

  fp16_result_collector #(.DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data),
    .out_class(out_class), .out_ready(out_ready),
    .level(level), .clr_stat(clr_stat),
    .zero_cnt(zero_cnt), .sub_cnt(sub_cnt),
    .inf_cnt(inf_cnt), .nan_cnt(nan_cnt), .sticky(sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; clr_stat = 1'b0;
    #12;
    checks++;
    if (level !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags lvl=%0d ov=%b ir=%b exp 0 0 1",
               level, out_valid, in_ready);
    end
    checks++;
    if ({zero_cnt, sub_cnt, inf_cnt, nan_cnt, sticky} !== '0) begin
      errors++;
      $display("FAIL reset_stats got %h %h %h %h %b exp zeros",
               zero_cnt, sub_cnt, inf_cnt, nan_cnt, sticky);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 16'h3C00;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h3C00 || out_class !== 3'b010
        || level !== 3'd1) begin
      errors++;
      $display("FAIL single_push ov=%b d=%h c=%b lvl=%0d exp 1 3c00 010 1",
               out_valid, out_data, out_class, level);
    end
    checks++;
    if ({zero_cnt, sub_cnt, inf_cnt, nan_cnt, sticky} !== '0) begin
      errors++;
      $display("FAIL normal_uncounted got %h %h %h %h %b exp zeros",
               zero_cnt, sub_cnt, inf_cnt, nan_cnt, sticky);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (level !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pop lvl=%0d ov=%b exp 0 0", level, out_valid);
    end
  endtask

  task automatic test_fill();
    logic [15:0] w [4];
    w[0] = 16'h0000; w[1] = 16'h0001; w[2] = 16'h7C00; w[3] = 16'hFE01;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = w[i];
      step();
    end
    checks++;
    if (level !== 3'd4 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_level lvl=%0d ir=%b exp 4 0", level, in_ready);
    end
    checks++;
    if (zero_cnt !== 3'd1 || sub_cnt !== 3'd1 || inf_cnt !== 3'd1
        || nan_cnt !== 3'd1 || sticky !== 4'b1111) begin
      errors++;
      $display("FAIL fill_stats got %0d %0d %0d %0d %b exp 1 1 1 1 1111",
               zero_cnt, sub_cnt, inf_cnt, nan_cnt, sticky);
    end
    in_data = 16'h0000;
    step();
    checks++;
    if (level !== 3'd4 || zero_cnt !== 3'd1) begin
      errors++;
      $display("FAIL full_ignore lvl=%0d zc=%0d exp 4 1", level, zero_cnt);
    end
    checks++;
    if (out_data !== 16'h0000 || out_class !== 3'b000) begin
      errors++;
      $display("FAIL fill_head d=%h c=%b exp 0000 000", out_data, out_class);
    end
  endtask

  task automatic test_full_pop();
    in_valid = 1'b1; in_data = 16'h3C00; out_ready = 1'b1;
    step();
    checks++;
    if (level !== 3'd3 || out_data !== 16'h0001 || out_class !== 3'b001) begin
      errors++;
      $display("FAIL full_pop lvl=%0d d=%h c=%b exp 3 0001 001",
               level, out_data, out_class);
    end
    in_data = 16'h4000;
    step();
    in_data = 16'h4200;
    step();
    in_valid = 1'b0;
    checks++;
    if (level !== 3'd3 || out_data !== NAN1 || out_class !== 3'b100) begin
      errors++;
      $display("FAIL push_pop lvl=%0d d=%h c=%b exp 3 %h 100",
               level, out_data, out_class, NAN1);
    end
    step();
    checks++;
    if (out_data !== 16'h4000 || out_class !== 3'b010) begin
      errors++;
      $display("FAIL order_1 d=%h c=%b exp 4000 010", out_data, out_class);
    end
    step();
    checks++;
    if (out_data !== 16'h4200 || level !== 3'd1) begin
      errors++;
      $display("FAIL order_2 d=%h lvl=%0d exp 4200 1", out_data, level);
    end
    step();
    out_ready = 1'b0;
    checks++;
    if (level !== 3'd0 || nan_cnt !== 3'd1 || zero_cnt !== 3'd1) begin
      errors++;
      $display("FAIL drain lvl=%0d nc=%0d zc=%0d exp 0 1 1",
               level, nan_cnt, zero_cnt);
    end
  endtask

  task automatic test_nan();
    in_valid = 1'b1; in_data = 16'h7D00;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_data !== NAN2 || out_class !== 3'b100 || nan_cnt !== 3'd2) begin
      errors++;
      $display("FAIL nan_store d=%h c=%b nc=%0d exp %h 100 2",
               out_data, out_class, nan_cnt, NAN2);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_clr();
    in_valid = 1'b1; in_data = 16'h7C00; clr_stat = 1'b1;
    step();
    clr_stat = 1'b0; in_valid = 1'b0;
    checks++;
    if (inf_cnt !== 3'd0 || sticky !== 4'b0000 || zero_cnt !== 3'd0
        || nan_cnt !== 3'd0) begin
      errors++;
      $display("FAIL clr_stats ic=%0d st=%b zc=%0d nc=%0d exp 0 0000 0 0",
               inf_cnt, sticky, zero_cnt, nan_cnt);
    end
    checks++;
    if (level !== 3'd1 || out_data !== 16'h7C00 || out_class !== 3'b011) begin
      errors++;
      $display("FAIL clr_push lvl=%0d d=%h c=%b exp 1 7c00 011",
               level, out_data, out_class);
    end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (inf_cnt !== 3'd1 || sticky !== 4'b0100 || level !== 3'd2) begin
      errors++;
      $display("FAIL post_clr ic=%0d st=%b lvl=%0d exp 1 0100 2",
               inf_cnt, sticky, level);
    end
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    step();
    step();
    clr_stat = 1'b1;
    step();
    clr_stat = 1'b0;
    in_valid = 1'b1; in_data = 16'h8000;
    for (int i = 0; i < 9; i++) step();
    in_valid = 1'b0;
    checks++;
    if (zero_cnt !== 3'd7 || sticky !== 4'b0001 || level !== 3'd1) begin
      errors++;
      $display("FAIL saturate zc=%0d st=%b lvl=%0d exp 7 0001 1",
               zero_cnt, sticky, level);
    end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 16'h3C00 + 16'(i);
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (level !== 3'd3) begin
      errors++;
      $display("FAIL pre_reset lvl=%0d exp 3", level);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || level !== 3'd0 || in_ready !== 1'b1
        || zero_cnt !== 3'd0 || sticky !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset ov=%b lvl=%0d ir=%b zc=%0d st=%b exp 0 0 1 0 0",
               out_valid, level, in_ready, zero_cnt, sticky);
    end
    #1 rst_n = 1'b1;
    step();
    in_valid = 1'b1; in_data = 16'h4000;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h4000 || level !== 3'd1) begin
      errors++;
      $display("FAIL after_reset ov=%b d=%h lvl=%0d exp 1 4000 1",
               out_valid, out_data, level);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_fill();
    test_full_pop();
    test_nan();
    test_clr();
    test_saturate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
